// File: rtl/phi_node_stage.sv
// Elastic PHI merge: lowest-index tagged lane wins and is pushed into a 2-entry FIFO.
// When the FIFO is empty the outputs hold the last popped value; multi-tag accepts are counted.
module phi_node_stage #(
  parameter  int NUM_IN = 4,
  parameter  int DATA_W = 32,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*(DATA_W+1)-1:0] in_lanes,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [SEL_W-1:0]             out_sel,
  input  logic                         clr_stats,
  output logic                         conflict,
  output logic [15:0]                  conflict_cnt
);

  logic [NUM_IN-1:0]             tags;
  logic [NUM_IN-1:0][DATA_W-1:0] lane_data;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign tags[g]      = in_lanes[g*(DATA_W+1) + DATA_W];
    assign lane_data[g] = in_lanes[g*(DATA_W+1) +: DATA_W];
  end

  logic [1:0][DATA_W-1:0] buf_data_q, buf_data_d;
  logic [1:0][SEL_W-1:0]  buf_sel_q, buf_sel_d;
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [DATA_W-1:0]      hold_data_q, hold_data_d;
  logic [SEL_W-1:0]       hold_sel_q, hold_sel_d;
  logic                   conflict_q, conflict_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [DATA_W-1:0] win_data;
  logic [SEL_W-1:0]  win_sel;
  logic              any_tag, multi_tag, push, pop;

  // Descending scan so the lowest tagged index is the final assignment.
  always_comb begin
    win_data = '0;
    win_sel  = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (tags[i]) begin
        win_data = lane_data[i];
        win_sel  = SEL_W'(i);
      end
    end
  end

  assign any_tag   = |tags;
  assign multi_tag = |(tags & (tags - NUM_IN'(1)));
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = any_tag & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_sel_d   = buf_sel_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    conflict_d  = conflict_q;
    cnt_d       = cnt_q;

    if (push) begin
      buf_data_d[wr_ptr_q] = win_data;
      buf_sel_d[wr_ptr_q]  = win_sel;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      hold_data_d = buf_data_q[rd_ptr_q];
      hold_sel_d  = buf_sel_q[rd_ptr_q];
      rd_ptr_d    = ~rd_ptr_q;
    end
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    if (clr_stats) begin
      conflict_d = 1'b0;
      cnt_d      = '0;
    end else if (push && multi_tag) begin
      conflict_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q  <= '0;
      buf_sel_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      conflict_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_sel_q   <= buf_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      conflict_q  <= conflict_d;
      cnt_q       <= cnt_d;
    end
  end

  // Empty buffer shows the last popped entry so the PHI value stays stable.
  assign out_data     = out_valid ? buf_data_q[rd_ptr_q] : hold_data_q;
  assign out_sel      = out_valid ? buf_sel_q[rd_ptr_q]  : hold_sel_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_phi_node_stage.sv
// Bench for phi_node_stage: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_phi_node_stage;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_IN*(DATA_W+1)-1:0] in_lanes;
  logic                         in_ready, out_valid, out_ready, clr_stats, conflict;
  logic [DATA_W-1:0]            out_data;
  logic [SEL_W-1:0]             out_sel;
  logic [15:0]                  conflict_cnt;

  logic [NUM_IN-1:0]             tb_tag;
  logic [NUM_IN-1:0][DATA_W-1:0] tb_dat;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [DATA_W-1:0] d; logic [SEL_W-1:0] s; } entry_t;
  entry_t mq[$];
  entry_t m_hold;
  bit     m_conf;
  int     m_cnt;

  phi_node_stage #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_lanes(in_lanes), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .clr_stats(clr_stats), .conflict(conflict),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_lanes = '0;
    for (int i = 0; i < NUM_IN; i++) in_lanes[i*(DATA_W+1) +: DATA_W+1] = {tb_tag[i], tb_dat[i]};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_hold = '{d: '0, s: '0};
    m_conf = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge from the current inputs, then step the DUT.
  task automatic tick();
    int  ntag, win;
    bit  push, pop;
    ntag = 0; win = -1;
    for (int i = 0; i < NUM_IN; i++)
      if (tb_tag[i]) begin ntag++; if (win < 0) win = i; end
    pop  = (mq.size() > 0) && out_ready;
    push = (ntag > 0) && (mq.size() < 2);
    if (clr_stats) begin m_conf = 0; m_cnt = 0; end
    else if (push && ntag > 1) begin m_conf = 1; if (m_cnt < 65535) m_cnt++; end
    if (pop) m_hold = mq.pop_front();
    if (push) mq.push_back('{d: tb_dat[win], s: SEL_W'(win)});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tb_tag = '0; tb_dat = '0; out_ready = 1'b0; clr_stats = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #23;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_chk++; if (out_data !== '0 || out_sel !== '0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_sel); end
    n_chk++; if (conflict !== 1'b0 || conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats got %b/%0d want 0/0", conflict, conflict_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_lane();
    out_ready = 1'b1;
    tb_tag = 4'b0100; tb_dat[2] = 32'h0000_00AA;
    tick();
    tb_tag = '0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b want 1", out_valid); end
    n_chk++; if (out_data !== 32'hAA || out_sel !== 2'd2) begin n_fail++; $display("FAIL t1_data got %h/%0d want aa/2", out_data, out_sel); end
    n_chk++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL t1_conflict got %b want 0", conflict); end
    tick();
    n_chk++; if (out_valid !== 1'b0 || out_data !== 32'hAA) begin n_fail++; $display("FAIL t1_hold got %b/%h want 0/aa", out_valid, out_data); end
  endtask

  task automatic test_conflict();
    tb_tag = 4'b1010; tb_dat[1] = 32'h11; tb_dat[3] = 32'h33;
    tick();
    tb_tag = '0;
    n_chk++; if (out_data !== 32'h11 || out_sel !== 2'd1) begin n_fail++; $display("FAIL t2_data got %h/%0d want 11/1", out_data, out_sel); end
    n_chk++; if (conflict !== 1'b1 || conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL t2_stats got %b/%0d want 1/1", conflict, conflict_cnt); end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    tb_tag = 4'b0001; tb_dat[0] = 32'h5; tick();
    tb_dat[0] = 32'h6; tick();
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL t3_full got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
    n_chk++; if (out_data !== 32'h5) begin n_fail++; $display("FAIL t3_head got %h want 5", out_data); end
    tb_dat[0] = 32'h7; tick();
    n_chk++; if (out_data !== 32'h5 || in_ready !== 1'b0) begin n_fail++; $display("FAIL t3_ignore got %h/%b want 5/0", out_data, in_ready); end
    tb_tag = '0; out_ready = 1'b1; tick();
    n_chk++; if (out_data !== 32'h6 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_second got %h/%b/%b want 6/1/1", out_data, out_valid, in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t3_empty got %b want 0", out_valid); end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || out_data !== 32'h6 || out_sel !== 2'd0) begin
        n_fail++; $display("FAIL t4_hold cyc %0d got %b/%h/%0d want 0/6/0", c, out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_saturate();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b1;
    tb_tag = 4'b0011; tb_dat[0] = 32'hC0; tb_dat[1] = 32'hC1;
    for (int c = 0; c < 65540; c++) tick();
    n_chk++; if (conflict_cnt !== 16'hFFFF || conflict !== 1'b1) begin n_fail++; $display("FAIL t5_sat got %h/%b want ffff/1", conflict_cnt, conflict); end
    n_chk++; if (out_data !== 32'hC0 || out_sel !== 2'd0) begin n_fail++; $display("FAIL t5_data got %h/%0d want c0/0", out_data, out_sel); end
    clr_stats = 1'b1; tick();
    n_chk++; if (conflict_cnt !== 16'd0 || conflict !== 1'b0) begin n_fail++; $display("FAIL t5_clr_wins got %h/%b want 0/0", conflict_cnt, conflict); end
    clr_stats = 1'b0; tb_tag = '0; tick(); tick();
    n_chk++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL t5_idle got %h want 0", conflict_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        tb_tag[i] = ($urandom_range(0, 3) == 0);
        tb_dat[i] = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 30) == 0);
      tick();
      n_chk++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
        n_fail++; $display("FAIL rnd_flow cyc %0d got vld=%b rdy=%b want qsize=%0d", c, out_valid, in_ready, mq.size());
      end
      n_chk++;
      if (mq.size() != 0) begin
        if (out_data !== mq[0].d || out_sel !== mq[0].s) begin
          n_fail++; $display("FAIL rnd_head cyc %0d got %h/%0d want %h/%0d", c, out_data, out_sel, mq[0].d, mq[0].s);
        end
      end else if (out_data !== m_hold.d || out_sel !== m_hold.s) begin
        n_fail++; $display("FAIL rnd_hold cyc %0d got %h/%0d want %h/%0d", c, out_data, out_sel, m_hold.d, m_hold.s);
      end
      n_chk++;
      if (conflict !== m_conf || conflict_cnt !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_stats cyc %0d got %b/%0d want %b/%0d", c, conflict, conflict_cnt, m_conf, m_cnt);
      end
    end
    clr_stats = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; tb_tag = 4'b1000; tb_dat[3] = 32'hDEAD;
    tick(); tick();
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t6_full got rdy=%b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL t6_async got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_chk++; if (out_data !== '0 || out_sel !== '0 || conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_clear got %h/%0d/%0d want 0/0/0", out_data, out_sel, conflict_cnt); end
    tb_tag = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    n_chk++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL t6_after got %b/%h want 0/0", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_conflict();
    test_backpressure();
    test_hold();
    test_saturate();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
